mode_sequencer: RTL and testbench

//  Parametrised successor to the board-level mode selector. Debounces the two
//  DE10-Lite push keys and runs them through a fully synchronous mode counter
//  on MAX10_CLK1_50. The counter wraps at NUM_MODES and supports return-to-zero.
//  A KEY1 press toggles freeze. The block registers the selected DATA_W-wide

---
 rtl/project1_pkg.sv | 21 ++
 rtl/key_debouncer.sv | 57 +++++
 rtl/mode_sequencer.sv | 99 +++++++++
 tb/tb_mode_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/project1_pkg.sv
// Shared constants for the DE10-Lite mode selector: key indices, debounce
// default and the layout of one result bundle.
package project1_pkg;

  // Key indices into the KEY bus
  localparam int unsigned KEY_ADV = 0;
  localparam int unsigned KEY_MOD = 1;

  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_50MHZ_10MS = 500000;

  // Result bundle layout: HEX0 [7:0], HEX1 [15:8], LEDR [25:16]
  localparam int unsigned HEX0_LSB  = 0;
  localparam int unsigned HEX0_W    = 8;
  localparam int unsigned HEX1_LSB  = 8;
  localparam int unsigned HEX1_W    = 8;
  localparam int unsigned LEDR_LSB  = 16;
  localparam int unsigned LEDR_W    = 10;
  localparam int unsigned BUNDLE_W  = HEX0_W + HEX1_W + LEDR_W;

endpackage

// File: rtl/key_debouncer.sv
// Debounces one raw active-low key: 2-FF synchroniser followed by a stability
// counter. Emits a registered 1-cycle pulse when the accepted level goes 1->0.
module key_debouncer
  import project1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic MAX10_CLK1_50,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: count while the synced level disagrees; accept on the count
  // that reaches DEBOUNCE_CYCLES, so the pulse appears 2+D edges after the key drops.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = level_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset treats the key as released
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Mode selector: debounced KEY0 advances a wrapping mode counter, KEY1 toggles
// display freeze, KEY0 with KEY1 held returns to mode 0. The selected bundle
// from the packed per-mode bus is registered onto disp_data.
module mode_sequencer
  import project1_pkg::*;
#(
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned DATA_W          = BUNDLE_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS,
  localparam int unsigned MODE_W = $clog2(NUM_MODES)
) (
  input  logic                        MAX10_CLK1_50,
  input  logic                        reset,
  input  logic [1:0]                  KEY,
  input  logic [NUM_MODES*DATA_W-1:0] mode_data,
  output logic [MODE_W-1:0]           mode,
  output logic [DATA_W-1:0]           disp_data,
  output logic                        frozen,
  output logic                        mode_changed
);

  logic adv_level, adv_press;
  logic mod_level, mod_press;

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              frozen_q, frozen_d;
  logic              changed_q, changed_d;
  logic [DATA_W-1:0] disp_q;
  logic [DATA_W-1:0] slices [NUM_MODES];
  logic [DATA_W-1:0] sel_data;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_adv (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .reset        (reset),
    .key_n        (KEY[KEY_ADV]),
    .level        (adv_level),
    .press        (adv_press)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_mod (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .reset        (reset),
    .key_n        (KEY[KEY_MOD]),
    .level        (mod_level),
    .press        (mod_press)
  );

  // Unpack the per-mode bus and pick the slice for the current mode
  always_comb begin
    for (int m = 0; m < NUM_MODES; m++) begin
      slices[m] = mode_data[m*DATA_W +: DATA_W];
    end
    sel_data = slices[mode_q];
  end

  // Event priority: return-to-zero, advance, freeze toggle; KEY1 alone while
  // KEY0 is held is ignored
  always_comb begin
    mode_d   = mode_q;
    frozen_d = frozen_q;
    if (adv_press && (!mod_level || mod_press)) begin
      mode_d   = '0;
      frozen_d = 1'b0;
    end else if (adv_press) begin
      mode_d   = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
      frozen_d = 1'b0;
    end else if (mod_press && adv_level) begin
      frozen_d = ~frozen_q;
    end
    changed_d = (mode_d != mode_q);
  end

  // Mode, freeze and display registers; display samples the pre-update mode
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      mode_q    <= '0;
      frozen_q  <= 1'b0;
      changed_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      frozen_q  <= frozen_d;
      changed_q <= changed_d;
      if (!frozen_q) begin
        disp_q <= sel_data;
      end
    end
  end

  assign mode         = mode_q;
  assign frozen       = frozen_q;
  assign mode_changed = changed_q;
  assign disp_data    = disp_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with NUM_MODES=4, DATA_W=8, D=4.
module tb_mode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  KEY;
  logic [31:0] mode_data;
  logic [1:0]  mode;
  logic [7:0]  disp_data;
  logic        frozen;
  logic        mode_changed;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int p0;

  mode_sequencer #(
    .NUM_MODES      (4),
    .DATA_W         (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .KEY          (KEY),
    .mode_data    (mode_data),
    .mode         (mode),
    .disp_data    (disp_data),
    .frozen       (frozen),
    .mode_changed (mode_changed)
  );

  always #5 clk = ~clk;

  // Count mode_changed pulses, sampled mid-cycle
  always @(negedge clk) if (mode_changed === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold key k low for lo cycles, then released for hi cycles
  task automatic press(input int k, input int lo, input int hi);
    KEY[k] = 1'b0;
    step(lo);
    KEY[k] = 1'b1;
    step(hi);
  endtask

  function automatic logic [7:0] slice(input int m);
    logic [31:0] d;
    d = mode_data;
    return d[m*8 +: 8];
  endfunction

  int exp_modes [5] = '{1, 2, 3, 0, 1};

  initial begin
    reset     = 1'b1;
    KEY       = 2'b11;
    mode_data = 32'h43_32_21_10;
    step(3);
    check("rst_mode", mode, 0);
    check("rst_disp", disp_data, 0);
    check("rst_frozen", frozen, 0);
    check("rst_changed", mode_changed, 0);
    reset = 1'b0;
    step(20);
    check("idle_mode", mode, 0);
    check("idle_pulses", pulses, 0);

    // Test 2: five clean presses; first one timed exactly
    KEY[0] = 1'b0;
    step(6);
    check("lat_before", mode, 0);
    step(1);
    check("lat_mode", mode, 1);
    check("lat_pulse", mode_changed, 1);
    step(1);
    KEY[0] = 1'b1;
    step(8);
    check("p0_mode", mode, exp_modes[0]);
    check("p0_disp", disp_data, slice(exp_modes[0]));
    for (int i = 1; i < 5; i++) begin
      press(0, 8, 8);
      check($sformatf("p%0d_mode", i), mode, exp_modes[i]);
      check($sformatf("p%0d_disp", i), disp_data, slice(exp_modes[i]));
    end
    check("p_pulses", pulses, 5);

    // Test 3: bounce rejected, then one clean 6-cycle press
    p0 = pulses;
    press(0, 3, 1);
    press(0, 3, 10);
    check("bounce_mode", mode, 1);
    check("bounce_pulses", pulses, p0);
    press(0, 6, 8);
    check("b6_mode", mode, 2);
    check("b6_pulses", pulses, p0 + 1);

    // Test 4: freeze at mode 1
    press(0, 8, 8);
    press(0, 8, 8);
    press(0, 8, 8);
    check("fz_mode", mode, 1);
    mode_data[15:8] = 8'hA5;
    step(2);
    press(1, 8, 8);
    check("fz_on", frozen, 1);
    check("fz_disp", disp_data, 8'hA5);
    mode_data[15:8] = 8'h3C;
    step(3);
    check("fz_hold", disp_data, 8'hA5);
    KEY[1] = 1'b0;
    step(7);
    check("unfz_frozen", frozen, 0);
    check("unfz_disp_old", disp_data, 8'hA5);
    step(1);
    check("unfz_disp_new", disp_data, 8'h3C);
    KEY[1] = 1'b1;
    step(8);
    check("unfz_mode", mode, 1);

    // Test 5: return-to-zero from mode 2 with KEY1 held (its press freezes)
    press(0, 8, 8);
    check("rtz_pre_mode", mode, 2);
    KEY[1] = 1'b0;
    step(8);
    check("rtz_pre_frozen", frozen, 1);
    p0 = pulses;
    KEY[0] = 1'b0;
    step(8);
    check("rtz_mode", mode, 0);
    check("rtz_frozen", frozen, 0);
    check("rtz_pulses", pulses, p0 + 1);
    KEY = 2'b11;
    step(8);
    // Same-cycle KEY0+KEY1 at mode 0
    p0 = pulses;
    KEY = 2'b00;
    step(8);
    KEY = 2'b11;
    step(8);
    check("both_mode", mode, 0);
    check("both_frozen", frozen, 0);
    check("both_pulses", pulses, p0);

    // Test 6: reset mid-press at mode 3
    press(0, 8, 8);
    press(0, 8, 8);
    press(0, 8, 8);
    check("mid_pre_mode", mode, 3);
    KEY[0] = 1'b0;
    step(2);
    reset  = 1'b1;
    KEY[0] = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_mode", mode, 0);
    check("mid_rst_changed", mode_changed, 0);
    p0 = pulses;
    step(20);
    check("mid_mode", mode, 0);
    check("mid_pulses", pulses, p0);
    check("mid_disp", disp_data, slice(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
